// File: rtl/hsclk_sel_ctrl_pkg.sv
// rtl/hsclk_sel_ctrl_pkg.sv - shared state encoding, divider codes and decode helpers
// Ports: none (package).
package hsclk_sel_ctrl_pkg;

    typedef enum logic [2:0] {
        LS_RUN  = 3'd0,
        LS_HOLD = 3'd1,
        TO_HS   = 3'd2,
        HS_RUN  = 3'd3,
        TO_LS   = 3'd4
    } state_t;

    localparam logic [1:0] DIV2 = 2'b00;
    localparam logic [1:0] DIV4 = 2'b01;
    localparam logic [1:0] DIV6 = 2'b10;

    function automatic logic is_ls(input state_t s);
        return (s == LS_RUN) || (s == LS_HOLD);
    endfunction

    function automatic logic wants_hs(input state_t s);
        return (s == TO_HS) || (s == HS_RUN);
    endfunction

    function automatic logic in_transit(input state_t s);
        return (s == TO_HS) || (s == TO_LS);
    endfunction

    // Any code other than /2 or /4 selects /6 in the switch; store it canonically.
    function automatic logic [1:0] div_norm(input logic [1:0] v);
        case (v)
            2'b00:   return DIV2;
            2'b01:   return DIV4;
            default: return DIV6;
        endcase
    endfunction

endpackage

// File: rtl/hsclk_sel_ctrl_if.sv
// rtl/hsclk_sel_ctrl_if.sv - signal bundle between the controller and its environment
// Ports: none; modport slave is the controller side, modport master the driving side.
//   inputs to controller : host_access_req, force_ls, cfg_wr, cfg_div_sel[1:0],
//                          hsclk_selected, lsclk_selected
//   outputs of controller: hsclk_sel, cpuclk_div_sel[1:0], ls_active, switching, div_pending
interface hsclk_sel_ctrl_if;
    logic       host_access_req;
    logic       force_ls;
    logic       cfg_wr;
    logic [1:0] cfg_div_sel;
    logic       hsclk_selected;
    logic       lsclk_selected;
    logic       hsclk_sel;
    logic [1:0] cpuclk_div_sel;
    logic       ls_active;
    logic       switching;
    logic       div_pending;

    modport master (
        output host_access_req, force_ls, cfg_wr, cfg_div_sel, hsclk_selected, lsclk_selected,
        input  hsclk_sel, cpuclk_div_sel, ls_active, switching, div_pending
    );

    modport slave (
        input  host_access_req, force_ls, cfg_wr, cfg_div_sel, hsclk_selected, lsclk_selected,
        output hsclk_sel, cpuclk_div_sel, ls_active, switching, div_pending
    );
endinterface

// File: rtl/hsclk_sel_ctrl_sync2.sv
// rtl/hsclk_sel_ctrl_sync2.sv - two-flop synchroniser, asynchronous active-low reset to 0
// Ports: clk (clock), rst_b (async active-low reset), d (async input), q (synchronised output)
module sync2 (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/hsclk_sel_ctrl.sv
// rtl/hsclk_sel_ctrl.sv - CPU clock-select controller: HS/LS switch sequencing and divider update gating
// Optional feature macro: LS_HOLDOFF_EN (adds LS_HOLD and the hold-off counter).
// Ports:
//   hsclk_in - sole clock, rising edge
//   rst_b    - asynchronous active-low reset
//   bus      - hsclk_sel_ctrl_if.slave: host_access_req, force_ls, cfg_wr, cfg_div_sel,
//              hsclk_selected, lsclk_selected in; hsclk_sel, cpuclk_div_sel, ls_active,
//              switching, div_pending out
module hsclk_sel_ctrl
    import hsclk_sel_ctrl_pkg::*;
#(
    parameter int unsigned HOLDOFF_CYCLES = 16,
    parameter logic [1:0]  DIV_RESET      = DIV4
) (
    input  logic            hsclk_in,
    input  logic            rst_b,
    hsclk_sel_ctrl_if.slave bus
);
    state_t     state;
    state_t     state_nxt;
    logic       hs_s;
    logic       ls_s;
    logic       req;
    logic       hsclk_sel_q;
    logic       ls_active_q;
    logic       switching_q;
    logic [1:0] div_q;
    logic [1:0] pend_q;
    logic       pending_q;
    logic       apply;

    sync2 u_sync_hs (.clk(hsclk_in), .rst_b(rst_b), .d(bus.hsclk_selected), .q(hs_s));
    sync2 u_sync_ls (.clk(hsclk_in), .rst_b(rst_b), .d(bus.lsclk_selected), .q(ls_s));

    assign req = bus.host_access_req | bus.force_ls;

`ifdef LS_HOLDOFF_EN
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF_CYCLES - 1);

    logic [7:0] cnt;
    logic [7:0] cnt_nxt;

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) cnt <= 8'd0;
        else        cnt <= cnt_nxt;
    end
`else
    // HOLDOFF_CYCLES has no effect without the hold-off state.
    logic unused_holdoff;
    assign unused_holdoff = (HOLDOFF_CYCLES != 0);
`endif

    always_comb begin
        state_nxt = state;
`ifdef LS_HOLDOFF_EN
        cnt_nxt = cnt;
`endif
        case (state)
            LS_RUN: begin
                if (!req) begin
`ifdef LS_HOLDOFF_EN
                    state_nxt = LS_HOLD;
                    cnt_nxt   = HOLD_LOAD;
`else
                    // A pending divider write lands first; hsclk_sel rises a cycle later.
                    if (!pending_q) state_nxt = TO_HS;
`endif
                end
            end
`ifdef LS_HOLDOFF_EN
            LS_HOLD: begin
                if (req)                 state_nxt = LS_RUN;
                else if (cnt != 8'd0)    cnt_nxt   = cnt - 8'd1;
                else if (!pending_q)     state_nxt = TO_HS;
            end
`endif
            // Abort wins over completion so a request always drops hsclk_sel next cycle.
            TO_HS: begin
                if (req)                 state_nxt = TO_LS;
                else if (hs_s && !ls_s)  state_nxt = HS_RUN;
            end
            HS_RUN: begin
                if (req)                 state_nxt = TO_LS;
            end
            TO_LS: begin
                if (ls_s && !hs_s)       state_nxt = LS_RUN;
            end
            default: state_nxt = LS_RUN;
        endcase
    end

    // Outputs are decoded from the next state so they are flops that track the state register.
    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state       <= LS_RUN;
            hsclk_sel_q <= 1'b0;
            ls_active_q <= 1'b1;
            switching_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            hsclk_sel_q <= wants_hs(state_nxt);
            ls_active_q <= is_ls(state_nxt);
            switching_q <= in_transit(state_nxt);
        end
    end

    // Divider only changes while the CPU runs from the host clock.
    assign apply = pending_q && is_ls(state_nxt);

    always_ff @(posedge hsclk_in or negedge rst_b) begin
        if (!rst_b) begin
            div_q     <= DIV_RESET;
            pend_q    <= DIV_RESET;
            pending_q <= 1'b0;
        end else begin
            if (apply) div_q <= pend_q;
            // A write coincident with an apply stays pending: the older value is applied now.
            if (bus.cfg_wr) begin
                pend_q    <= div_norm(bus.cfg_div_sel);
                pending_q <= 1'b1;
            end else if (apply) begin
                pending_q <= 1'b0;
            end
        end
    end

    assign bus.hsclk_sel      = hsclk_sel_q;
    assign bus.cpuclk_div_sel = div_q;
    assign bus.ls_active      = ls_active_q;
    assign bus.switching      = switching_q;
    assign bus.div_pending    = pending_q;
endmodule

// File: tb/tb_hsclk_sel_ctrl.sv
// tb/tb_hsclk_sel_ctrl.sv - self-checking bench for hsclk_sel_ctrl (honours LS_HOLDOFF_EN)
`timescale 1ns/1ps
module tb_hsclk_sel_ctrl;
    localparam int unsigned H = 16;
`ifdef LS_HOLDOFF_EN
    localparam int RISE = H + 1;
`else
    localparam int RISE = 1;
`endif
    localparam int M_LS   = 0;
    localparam int M_TOHS = 1;
    localparam int M_HS   = 2;
    localparam int M_TOLS = 3;

    logic clk    = 1'b0;
    logic rst_b  = 1'b0;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hsclk_sel_ctrl_if bus ();

    hsclk_sel_ctrl #(.HOLDOFF_CYCLES(H), .DIV_RESET(2'b01)) dut (
        .hsclk_in (clk),
        .rst_b    (rst_b),
        .bus      (bus)
    );

    // Reference model: LS dwell measured as a run of quiet cycles, feedback seen two edges late.
    int         m_mode  = M_LS;
    int         m_quiet = 0;
    logic [1:0] m_div   = 2'b01;
    logic [1:0] m_pval  = 2'b01;
    logic       m_pend  = 1'b0;
    logic [1:0] m_fb [$];
    logic [1:0] m_seen;
    logic       m_req;

    initial begin
        m_fb.push_back(2'b00);
        m_fb.push_back(2'b00);
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_mode  = M_LS;
            m_quiet = 0;
            m_div   = 2'b01;
            m_pend  = 1'b0;
            m_fb.delete();
            m_fb.push_back(2'b00);
            m_fb.push_back(2'b00);
        end else begin
            m_req  = bus.host_access_req | bus.force_ls;
            m_seen = m_fb.pop_front();
            m_fb.push_back({bus.hsclk_selected, bus.lsclk_selected});
            case (m_mode)
                M_LS: begin
                    if (m_req) m_quiet = 0;
                    else begin
                        m_quiet = m_quiet + 1;
                        if (m_quiet >= RISE && !m_pend) m_mode = M_TOHS;
                    end
                end
                M_TOHS: begin
                    if (m_req)                  m_mode = M_TOLS;
                    else if (m_seen == 2'b10)   m_mode = M_HS;
                end
                M_HS:   if (m_req) m_mode = M_TOLS;
                default: begin
                    if (m_seen == 2'b01) begin
                        m_mode  = M_LS;
                        m_quiet = 0;
                    end
                end
            endcase
            if (m_pend && m_mode == M_LS) begin
                m_div  = m_pval;
                m_pend = 1'b0;
            end
            if (bus.cfg_wr) begin
                m_pval = (bus.cfg_div_sel >= 2'd2) ? 2'b10 : bus.cfg_div_sel;
                m_pend = 1'b1;
            end
        end
    end

    logic [5:0] cmp_exp;
    logic [5:0] cmp_act;

    always @(negedge clk) begin
        if (chk_en) begin
            cmp_exp = {(m_mode == M_TOHS || m_mode == M_HS), m_div, (m_mode == M_LS),
                       (m_mode == M_TOHS || m_mode == M_TOLS), m_pend};
            cmp_act = {bus.hsclk_sel, bus.cpuclk_div_sel, bus.ls_active, bus.switching, bus.div_pending};
            checks++;
            if (cmp_act !== cmp_exp) begin
                errors++;
                $display("FAIL model_cmp t=%0t actual(sel,div,ls,sw,pend)=%b required=%b",
                         $time, cmp_act, cmp_exp);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clock-switch stand-in: break-before-make with a random settle time.
    logic sw_target = 1'b0;
    int   sw_cnt    = 0;

    task automatic switch_emul();
        if (bus.hsclk_sel !== sw_target) begin
            sw_target          = bus.hsclk_sel;
            sw_cnt             = $urandom_range(1, 4);
            bus.hsclk_selected = 1'b0;
            bus.lsclk_selected = 1'b0;
        end else if (sw_cnt > 0) begin
            sw_cnt--;
            if (sw_cnt == 0) begin
                bus.hsclk_selected = sw_target;
                bus.lsclk_selected = ~sw_target;
            end
        end
    endtask

    task automatic switch_reset();
        sw_target          = 1'b0;
        sw_cnt             = 0;
        bus.hsclk_selected = 1'b0;
        bus.lsclk_selected = 1'b1;
    endtask

    int n;
    int p;
    int len;
    logic rose;

    initial begin
        bus.host_access_req = 1'b0;
        bus.force_ls        = 1'b0;
        bus.cfg_wr          = 1'b0;
        bus.cfg_div_sel     = 2'b00;
        bus.hsclk_selected  = 1'b0;
        bus.lsclk_selected  = 1'b1;
        rst_b = 1'b0;
        repeat (3) step();
        chk_en = 1'b1;

        chk("rst_hsclk_sel", int'(bus.hsclk_sel), 0);
        chk("rst_div", int'(bus.cpuclk_div_sel), 1);
        chk("rst_ls_active", int'(bus.ls_active), 1);
        chk("rst_switching", int'(bus.switching), 0);
        chk("rst_div_pending", int'(bus.div_pending), 0);

        rst_b = 1'b1;
        n = 0;
        while (n < 100 && bus.hsclk_sel !== 1'b1) begin step(); n++; end
        chk("rise_after_reset", n, RISE);

        bus.hsclk_selected = 1'b1;
        bus.lsclk_selected = 1'b0;
        n = 0;
        while (n < 20 && bus.switching !== 1'b0) begin step(); n++; end
        chk("hs_run_latency", n, 3);
        chk("hs_run_sel", int'(bus.hsclk_sel), 1);

        bus.cfg_wr      = 1'b1;
        bus.cfg_div_sel = 2'b10;
        step();
        bus.cfg_wr = 1'b0;
        step();
        step();
        chk("hs_wr_pending", int'(bus.div_pending), 1);
        chk("hs_wr_div_held", int'(bus.cpuclk_div_sel), 1);

        bus.host_access_req = 1'b1;
        step();
        bus.host_access_req = 1'b0;
        chk("req_to_sel_fall", int'(bus.hsclk_sel), 0);
        chk("to_ls_div_held", int'(bus.cpuclk_div_sel), 1);

        bus.hsclk_selected = 1'b0;
        bus.lsclk_selected = 1'b1;
        n = 0;
        while (n < 20 && bus.ls_active !== 1'b1) begin step(); n++; end
        chk("ls_entry_latency", n, 3);
        chk("ls_entry_div", int'(bus.cpuclk_div_sel), 2);
        chk("ls_entry_pending", int'(bus.div_pending), 0);

        n = 0;
        while (n < 100 && bus.hsclk_sel !== 1'b1) begin step(); n++; end
        chk("rerise_after_ls", n, RISE);

        #2;
        rst_b = 1'b0;
        #1;
        chk("async_rst_hsclk_sel", int'(bus.hsclk_sel), 0);
        chk("async_rst_div", int'(bus.cpuclk_div_sel), 1);
        chk("async_rst_ls_active", int'(bus.ls_active), 1);
        chk("async_rst_switching", int'(bus.switching), 0);
        chk("async_rst_pending", int'(bus.div_pending), 0);

        bus.host_access_req = 1'b1;
        step();
        rst_b = 1'b1;
        step();
        bus.cfg_wr      = 1'b1;
        bus.cfg_div_sel = 2'b00;
        step();
        chk("ls_wr_capture_pend", int'(bus.div_pending), 1);
        chk("ls_wr_capture_div", int'(bus.cpuclk_div_sel), 1);
        bus.cfg_div_sel = 2'b11;
        step();
        bus.cfg_wr = 1'b0;
        chk("ls_wr_apply_first", int'(bus.cpuclk_div_sel), 0);
        chk("ls_wr_new_pending", int'(bus.div_pending), 1);
        step();
        chk("ls_wr_apply_last", int'(bus.cpuclk_div_sel), 2);
        chk("ls_wr_cleared", int'(bus.div_pending), 0);

`ifdef LS_HOLDOFF_EN
        rose = 1'b0;
        for (int t = 0; t < 96; t++) begin
            bus.host_access_req = ((t / 8) % 2 == 1);
            step();
            if (bus.hsclk_sel === 1'b1) rose = 1'b1;
        end
        chk("toggle_never_hs", int'(rose), 0);
`endif

        switch_reset();
        for (int ph = 0; ph < 60; ph++) begin
            len = $urandom_range(10, 80);
            case ($urandom_range(0, 2))
                0:       p = 0;
                1:       p = 3;
                default: p = 40;
            endcase
            if (ph == 30) begin
                rst_b = 1'b0;
                step();
                rst_b = 1'b1;
                switch_reset();
            end
            for (int c = 0; c < len; c++) begin
                step();
                bus.host_access_req = ($urandom_range(0, 99) < p);
                bus.force_ls        = ($urandom_range(0, 99) < p / 4);
                bus.cfg_wr          = ($urandom_range(0, 15) == 0);
                bus.cfg_div_sel     = 2'($urandom_range(0, 3));
                switch_emul();
            end
        end

        step();
        chk_en = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hsclk_sel_ctrl.md
# hsclk_sel_ctrl

Upstream clock-selection controller for the CPU clock switch. It decides, on every `hsclk_in` edge, whether the CPU runs from the divided high-speed clock or the host (motherboard) clock. It drives `hsclk_sel` and `cpuclk_div_sel` into the PHI2 clock switch, and tracks the switch's `hsclk_selected`/`lsclk_selected` feedback through synchronisers. It also holds divider reprogramming back until the high-speed clock is deselected.

## Interface
- `HOLDOFF_CYCLES`, 16: `hsclk_in` cycles to stay slow after the last host access (used only with `LS_HOLDOFF_EN`); range 1–255.
- `DIV_RESET`, 2'b01: reset value of `cpuclk_div_sel`.
- `hsclk_in` input 1: sole clock; all state on its rising edge.
- `rst_b` input 1: asynchronous active-low reset.
- `host_access_req` input 1: level; the current CPU cycle targets motherboard space and needs the host clock.
- `force_ls` input 1: level; pins the CPU to the host clock.
- `cfg_wr` input 1: single-cycle strobe to load `cfg_div_sel`.
- `cfg_div_sel` input 2: requested divider: 00 = /2, 01 = /4, other = /6.
- `hsclk_selected` input 1: async feedback from the clock switch.
- `lsclk_selected` input 1: async feedback from the clock switch.
- `hsclk_sel` output 1: request for the high-speed clock.
- `cpuclk_div_sel` output 2: divider select to the clock switch.
- `ls_active` output 1: high in LS_RUN/LS_HOLD.
- `switching` output 1: high in TO_HS/TO_LS.
- `div_pending` output 1: a divider write is waiting to be applied.

## Operation
- Both feedback inputs pass through 2-flop synchronisers, giving `hs_s` and `ls_s`.
- The FSM has five states, encoded in 3 bits:
  - LS_RUN: if `!host_access_req && !force_ls`, go to LS_HOLD and load the counter with HOLDOFF_CYCLES-1.
  - LS_HOLD: the counter decrements each cycle. If `host_access_req` or `force_ls`, go to LS_RUN. When the counter reaches 0, go to TO_HS.
  - TO_HS: `hsclk_sel`=1. If `hs_s && !ls_s`, go to HS_RUN. If `host_access_req` or `force_ls`, go to TO_LS (abort).
  - HS_RUN: `hsclk_sel`=1. If `host_access_req` or `force_ls`, go to TO_LS.
  - TO_LS: `hsclk_sel`=0. If `ls_s && !hs_s`, go to LS_RUN. Requests are ignored here.
- `hsclk_sel` is registered and is 1 exactly in TO_HS and HS_RUN. It is a state-decoded flop, never combinational.
- Divider programming:
  - `cfg_wr` captures `cfg_div_sel` into a pending register and sets `div_pending`.
  - The pending value is copied to `cpuclk_div_sel` on the first cycle the FSM is in LS_RUN or LS_HOLD; `div_pending` clears on that same cycle.
  - A write made while in LS_RUN/LS_HOLD applies on the next cycle.
  - Back-to-back writes: the last write wins.
  - A new `cfg_wr` arriving in the same cycle as an apply wins: the new value is held pending and `div_pending` stays 1.
- Leaving LS_HOLD for TO_HS is blocked for one cycle if `div_pending` is set, so the apply lands before `hsclk_sel` rises.

## Timing
- Reset values: state LS_RUN, `hsclk_sel`=0, `cpuclk_div_sel`=DIV_RESET, `ls_active`=1, `switching`=0, `div_pending`=0, counter 0, synchronisers 0.
- Async reset mid-switch returns to LS_RUN immediately. This matches the clock switch, which resets to LS selected.
- Request to `hsclk_sel` fall: 1 cycle from HS_RUN or TO_HS.
- Feedback edge to state change: 3 cycles (2 sync + 1 FSM).
- Minimum LS-to-HS with `host_access_req` low: HOLDOFF_CYCLES + 1 cycles to `hsclk_sel` rise.
- Simultaneous `force_ls` and `host_access_req` behave identically to either one alone.

## Configuration
- `LS_HOLDOFF_EN` defined: LS_HOLD and the counter exist as above.
- `LS_HOLDOFF_EN` undefined: LS_HOLD and the counter are removed. LS_RUN goes to TO_HS one cycle after `host_access_req` and `force_ls` are both low, still subject to the `div_pending` one-cycle block. HOLDOFF_CYCLES is ignored.

## Structure
- Shared package holds:
  - the state enum (LS_RUN, LS_HOLD, TO_HS, HS_RUN, TO_LS);
  - divider encodings DIV2=2'b00, DIV4=2'b01, DIV6=2'b10.
- One sub-module, `sync2`: a 2-flop synchroniser with async active-low reset to 0. It is instantiated twice.

## Test plan
- Reset release with inputs idle and `LS_HOLDOFF_EN` defined, HOLDOFF_CYCLES=16 -> `hsclk_sel` rises at cycle 17. Return `hsclk_selected`=1, `lsclk_selected`=0 -> HS_RUN 3 cycles later, `switching`=0.
- `host_access_req` pulse in HS_RUN -> `hsclk_sel`=0 next cycle. Return `lsclk_selected`=1, `hsclk_selected`=0 -> LS_RUN 3 cycles later. Then 16 cycles idle -> back to TO_HS.
- `cfg_wr` with 2'b10 in HS_RUN -> `cpuclk_div_sel` holds 2'b01 and `div_pending`=1 until entry to LS_RUN. Then `cpuclk_div_sel`=2'b10 and `div_pending`=0 on that cycle.
- `host_access_req` toggling every 8 cycles in LS -> `hsclk_sel` never rises. The counter reloads on each LS_HOLD entry.
- `rst_b` asserted in TO_HS -> all outputs at reset values asynchronously, with `cpuclk_div_sel`=2'b01.
- `LS_HOLDOFF_EN` undefined, inputs idle after reset -> `hsclk_sel` rises 1 cycle after reset release.
